// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rns_pkg
// Brief   : Moduli, widths and residue word type for the {2^N+1, 2^N, 2^N-1} RNS.
// Revision: 1.0
// ============================================================================
package rns_pkg;

  localparam int N  = 5;
  localparam int M1 = (1 << N) + 1;
  localparam int M2 = (1 << N);
  localparam int M3 = (1 << N) - 1;
  localparam int M  = M2 * ((1 << (2 * N)) - 1);

  localparam int W1 = N + 1;
  localparam int W2 = N;
  localparam int W3 = N;
  localparam int WB = 3 * N;

  typedef struct packed {
    logic [W1-1:0] x1;
    logic [W2-1:0] x2;
    logic [W3-1:0] x3;
  } rns_word_t;

endpackage
`default_nettype wire

// File: rtl/mod_2n_pm1_reduce.sv
`default_nettype none
// ============================================================================
// Module  : mod_2n_pm1_reduce
// Brief   : Final reduction of an (N+2)-bit partial sum modulo 2^N+1 (PLUS=1)
//           or 2^N-1 (PLUS=0).
// Revision: 1.0
// ============================================================================
module mod_2n_pm1_reduce
  import rns_pkg::*;
#(
  parameter bit PLUS = 1'b1
) (
  input  logic [N+1:0]                din,
  output logic [(PLUS ? N : N-1):0]   res
);

  generate
    if (PLUS) begin : g_plus
      localparam logic [N+1:0] c_m1_wide = (N+2)'(M1);
      localparam logic [N:0]   c_m1      = (N+1)'(M1);

      logic [N:0] w_a;
      logic [N:0] w_b;

      // Input never exceeds 3*2^N-1, so two conditional subtracts suffice.
      assign w_a = (din >= c_m1_wide) ? (N+1)'(din - c_m1_wide) : din[N:0];
      assign w_b = (w_a >= c_m1) ? (w_a - c_m1) : w_a;
      assign res = w_b;
    end else begin : g_minus
      localparam logic [N-1:0] c_m3 = N'(M3);

      logic [N:0]   w_f1;
      logic [N-1:0] w_f2;

      // Two end-around-carry folds; the second can never carry out.
      assign w_f1 = {1'b0, din[N-1:0]} + (N+1)'(din[N+1:N]);
      assign w_f2 = w_f1[N-1:0] + N'(w_f1[N]);
      assign res  = (w_f2 == c_m3) ? '0 : w_f2;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/forward_converter_33_32_31_pipe.sv
`default_nettype none
// ============================================================================
// Module  : forward_converter_33_32_31_pipe
// Brief   : 2-stage binary-to-RNS converter, moduli {2^N+1, 2^N, 2^N-1}.
//           Define RNS_RANGE_CHECK_EN to flag inputs at or above the range M.
// Revision: 1.0
// ============================================================================
module forward_converter_33_32_31_pipe
  import rns_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3*N-1:0] in_bin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N:0]     out_x1,
  output logic [N-1:0]   out_x2,
  output logic [N-1:0]   out_x3,
  output logic           out_err
);

  localparam logic [N+1:0] c_m1 = (N+2)'(M1);

  logic [N-1:0] w_b0, w_b1, w_b2;
  logic [N+1:0] w_s31, w_d33;
  logic         w_s2_adv, w_accept;
  logic [N:0]   w_x1;
  logic [N-1:0] w_x3;

  logic         r_s1_valid;
  logic [N-1:0] r_r2;
  logic [N+1:0] r_s31;
  logic [N+1:0] r_d33;
  logic         r_s2_valid;
  rns_word_t    r_out;

  assign w_b0 = in_bin[N-1:0];
  assign w_b1 = in_bin[2*N-1:N];
  assign w_b2 = in_bin[3*N-1:2*N];

  assign w_s31 = (N+2)'(w_b0) + (N+2)'(w_b1) + (N+2)'(w_b2);
  // Adding the modulus before subtracting B1 keeps the result positive.
  assign w_d33 = (N+2)'(w_b0) + (N+2)'(w_b2) + c_m1 - (N+2)'(w_b1);

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  mod_2n_pm1_reduce #(.PLUS(1'b1)) u_red_m1 (
    .din (r_d33),
    .res (w_x1)
  );

  mod_2n_pm1_reduce #(.PLUS(1'b0)) u_red_m3 (
    .din (r_s31),
    .res (w_x3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_r2       <= '0;
      r_s31      <= '0;
      r_d33      <= '0;
      r_s2_valid <= 1'b0;
      r_out      <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_r2  <= w_b0;
        r_s31 <= w_s31;
        r_d33 <= w_d33;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_out.x1 <= w_x1;
        r_out.x2 <= r_r2;
        r_out.x3 <= w_x3;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_x1    = r_out.x1;
  assign out_x2    = r_out.x2;
  assign out_x3    = r_out.x3;

`ifdef RNS_RANGE_CHECK_EN
  localparam logic [3*N-1:0] c_range = (3*N)'(M);

  logic r_ov;
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ov  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ov <= (in_bin >= c_range);
      end
      if (w_s2_adv && r_s1_valid) begin
        r_err <= r_ov;
      end
    end
  end

  assign out_err = r_err;
`else
  assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire
